// File: rtl/board_pkg.sv
// Shared board geometry, cell colour codes and arbiter FSM states for the
// two-player playfield memory.
package board_pkg;

   localparam int BOARD_COLS  = 10;
   localparam int BOARD_ROWS  = 20;
   localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;
   localparam int P2_BASE     = BOARD_CELLS;
   localparam int CELL_W      = 3;

   typedef enum logic [CELL_W-1:0] {
      EMPTY = 3'd0,
      PC_I  = 3'd1,
      PC_O  = 3'd2,
      PC_T  = 3'd3,
      PC_S  = 3'd4,
      PC_J  = 3'd5,
      PC_L  = 3'd6,
      PC_Z  = 3'd7
   } cell_e;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_e;

endpackage

// File: rtl/board_mem.sv
// Single-port synchronous board RAM: one read or one write per cycle,
// read data registered and held until the next read.
module board_mem #(
   parameter int DEPTH = 400,
   parameter int AW    = 9,
   parameter int DW    = 3
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/board_ram_arbiter.sv
// Shares the two-player board RAM between display (priority) and two game
// requesters (round-robin), with a clear sweep. ARB_STARVE_GUARD_EN adds starvation guard.
module board_ram_arbiter
   import board_pkg::*;
#(
   parameter int CELLS      = BOARD_CELLS,
   parameter int AW         = 9,
   parameter int LAW        = 8,
   parameter int STARVE_LIM = 64
) (
   input  logic              pclk,
   input  logic              rstn,
   input  logic              disp_re,
   input  logic [AW-1:0]     disp_addr,
   output logic [CELL_W-1:0] disp_rdata,
   output logic              disp_miss,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [LAW-1:0]    p1_addr,
   input  logic [CELL_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [CELL_W-1:0] p1_rdata,
   input  logic              p2_req,
   input  logic              p2_we,
   input  logic [LAW-1:0]    p2_addr,
   input  logic [CELL_W-1:0] p2_wdata,
   output logic              p2_gnt,
   output logic              p2_rvalid,
   output logic [CELL_W-1:0] p2_rdata,
   input  logic              clr_req,
   output logic              busy
);

   localparam int            DEPTH     = 2 * CELLS;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   arb_state_e        state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic              rr_q, rr_d;
   logic              disp_rd_q, disp_rd_d, disp_zero_q, disp_zero_d;
   logic [CELL_W-1:0] disp_hold_q, disp_hold_d;
   logic [1:0]        rv_q, rv_d, zero_q, zero_d;
   logic [CELL_W-1:0] hold_q [2];
   logic [CELL_W-1:0] hold_d [2];
   logic [CELL_W-1:0] rdata  [2];

   logic [1:0]        req, we, ok, gnt, starve;
   logic [LAW-1:0]    laddr [2];
   logic [CELL_W-1:0] wdat  [2];
   logic              disp_ok, disp_srv, disp_kill;

   logic              mem_en, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [CELL_W-1:0] mem_wdata, mem_rdata;

   assign req      = {p2_req, p1_req};
   assign we       = {p2_we, p1_we};
   assign laddr[0] = p1_addr;
   assign laddr[1] = p2_addr;
   assign wdat[0]  = p1_wdata;
   assign wdat[1]  = p2_wdata;
   assign disp_ok  = disp_addr < AW'(DEPTH);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign ok[gi]     = laddr[gi] < LAW'(CELLS);
         assign rv_d[gi]   = gnt[gi] && !we[gi];
         assign zero_d[gi] = !ok[gi];
         // Out-of-range local addresses read back as 0 but still pulse rvalid.
         assign rdata[gi]  = rv_q[gi] ? (zero_q[gi] ? '0 : mem_rdata) : hold_q[gi];
         assign hold_d[gi] = rdata[gi];
      end
   endgenerate

`ifdef ARB_STARVE_GUARD_EN
   localparam int            WW       = $clog2(STARVE_LIM);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIM - 1);
   logic disp_miss_q, disp_miss_d;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_guard
         logic [WW-1:0] wait_q, wait_d;
         // Saturates one short of the limit, so the limit-th waiting cycle is forced.
         assign starve[gi] = req[gi] && (wait_q == WAIT_MAX);
         always_comb begin
            wait_d = wait_q;
            if (gnt[gi]) begin
               wait_d = '0;
            end else if (req[gi] && wait_q != WAIT_MAX) begin
               wait_d = wait_q + 1'b1;
            end
         end
         always_ff @(posedge pclk) begin
            if (rstn) wait_q <= '0;
            else      wait_q <= wait_d;
         end
      end
   endgenerate

   assign disp_miss_d = disp_re && !disp_srv;
   always_ff @(posedge pclk) begin
      if (rstn) disp_miss_q <= 1'b0;
      else      disp_miss_q <= disp_miss_d;
   end
   assign disp_kill = disp_miss_q;
`else
   assign starve    = '0;
   assign disp_kill = 1'b0;
`endif

   always_comb begin
      gnt  = '0;
      rr_d = rr_q;
      if (state_q == IDLE) begin
         if (|starve) begin
            if (&starve) begin
               gnt  = rr_q ? 2'b10 : 2'b01;
               rr_d = ~rr_q;
            end else begin
               gnt = starve;
            end
         end else if (!disp_re) begin
            if (&req) begin
               gnt  = rr_q ? 2'b10 : 2'b01;
               rr_d = ~rr_q;
            end else begin
               gnt = req;
            end
         end
      end
      disp_srv = disp_re && (gnt == 2'b00);
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = cnt_q;
      mem_wdata = '0;
      if (state_q == CLEAR && !disp_re) begin
         mem_en = 1'b1;
         mem_we = 1'b1;
      end else if (disp_srv) begin
         mem_en   = disp_ok;
         mem_addr = disp_addr;
      end else if (gnt[0]) begin
         mem_en    = ok[0];
         mem_we    = we[0];
         mem_addr  = AW'(laddr[0]);
         mem_wdata = wdat[0];
      end else if (gnt[1]) begin
         mem_en    = ok[1];
         mem_we    = we[1];
         mem_addr  = AW'(laddr[1]) + AW'(CELLS);
         mem_wdata = wdat[1];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (!disp_re) begin
               if (cnt_q == LAST_ADDR) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign disp_rd_d   = disp_srv;
   assign disp_zero_d = !disp_ok;
   assign disp_rdata  = disp_rd_q ? (disp_zero_q ? '0 : mem_rdata)
                                  : (disp_kill ? '0 : disp_hold_q);
   assign disp_hold_d = disp_rdata;

   always_ff @(posedge pclk) begin
      if (rstn) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         rr_q        <= 1'b0;
         disp_rd_q   <= 1'b0;
         disp_zero_q <= 1'b0;
         disp_hold_q <= '0;
         rv_q        <= '0;
         zero_q      <= '0;
         for (int i = 0; i < 2; i++) hold_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         disp_rd_q   <= disp_rd_d;
         disp_zero_q <= disp_zero_d;
         disp_hold_q <= disp_hold_d;
         rv_q        <= rv_d;
         zero_q      <= zero_d;
         for (int i = 0; i < 2; i++) hold_q[i] <= hold_d[i];
      end
   end

   board_mem #(.DEPTH(DEPTH), .AW(AW), .DW(CELL_W)) u_mem (
      .clk   (pclk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign p1_gnt    = gnt[0];
   assign p2_gnt    = gnt[1];
   assign p1_rvalid = rv_q[0];
   assign p2_rvalid = rv_q[1];
   assign p1_rdata  = rdata[0];
   assign p2_rdata  = rdata[1];
   assign disp_miss = disp_kill;
   assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter: a cell model plus a queue of expected
// read results, checked one cycle after each grant.
module tb_board_ram_arbiter;

   logic       pclk = 1'b0;
   logic       rstn, disp_re, disp_miss, clr_req, busy;
   logic [8:0] disp_addr;
   logic [2:0] disp_rdata;
   logic       p1_req, p1_we, p1_gnt, p1_rvalid;
   logic       p2_req, p2_we, p2_gnt, p2_rvalid;
   logic [7:0] p1_addr, p2_addr;
   logic [2:0] p1_wdata, p2_wdata, p1_rdata, p2_rdata;

   always #5 pclk = ~pclk;

   board_ram_arbiter dut (
      .pclk(pclk), .rstn(rstn),
      .disp_re(disp_re), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_miss(disp_miss),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
      .p2_gnt(p2_gnt), .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
      .clr_req(clr_req), .busy(busy)
   );

   typedef struct {int who; logic [2:0] val;} exp_t;
   exp_t       sb[$];
   logic [2:0] mdl [400];
   int         n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drv();
      @(posedge pclk); #1;
   endtask

   function automatic logic gnt_of(int who);
      return (who == 1) ? p1_gnt : p2_gnt;
   endfunction
   function automatic logic rv_of(int who);
      return (who == 1) ? p1_rvalid : p2_rvalid;
   endfunction
   function automatic logic [2:0] rd_of(int who);
      return (who == 1) ? p1_rdata : p2_rdata;
   endfunction

   task automatic set_req(int who, logic r, logic w, logic [7:0] a, logic [2:0] d);
      if (who == 1) begin p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; end
      else          begin p2_req = r; p2_we = w; p2_addr = a; p2_wdata = d; end
   endtask

   task automatic p_access(int who, logic w, int a, logic [2:0] d);
      int   phys;
      bit   got;
      exp_t e;
      phys = (who == 1) ? a : a + 200;
      drv();
      set_req(who, 1'b1, w, 8'(a), d);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge pclk);
         if (gnt_of(who)) got = 1;
         else drv();
      end
      if (!got) begin
         chk($sformatf("p%0d_gnt_timeout", who), 0, 1);
         drv();
         set_req(who, 1'b0, 1'b0, 8'd0, 3'd0);
         return;
      end
      if (w) begin
         if (a < 200) mdl[phys] = d;
      end else begin
         e.who = who;
         e.val = (a < 200) ? mdl[phys] : 3'd0;
         sb.push_back(e);
      end
      drv();
      set_req(who, 1'b0, 1'b0, 8'd0, 3'd0);
      @(negedge pclk);
      chk($sformatf("p%0d_rvalid a=%0d w=%0d", who, a, w), rv_of(who), !w);
      if (!w) begin
         e = sb.pop_front();
         chk($sformatf("p%0d_rdata a=%0d", who, a), rd_of(who), e.val);
         drv();
         @(negedge pclk);
         chk($sformatf("p%0d_rvalid_pulse", who), rv_of(who), 0);
         chk($sformatf("p%0d_rdata_hold", who), rd_of(who), e.val);
      end
      $display("p%0d %s local=%0d data=%0d", who, w ? "write" : "read", a, w ? d : e.val);
   endtask

   task automatic disp_read(int a);
      exp_t e;
      drv();
      disp_re = 1'b1;
      disp_addr = 9'(a);
      e.who = 0;
      e.val = (a < 400) ? mdl[a] : 3'd0;
      sb.push_back(e);
      @(negedge pclk);
      drv();
      disp_re = 1'b0;
      @(negedge pclk);
      e = sb.pop_front();
      chk($sformatf("disp_rdata a=%0d", a), disp_rdata, e.val);
      chk("disp_miss_idle", disp_miss, 0);
      $display("disp read addr=%0d data=%0d", a, disp_rdata);
   endtask

   // Caller has just released reset or issued clr_req; inputs are driven at posedge+1.
   task automatic count_sweep(bit toggle, int exp_cycles);
      int n = 0, gerr = 0;
      bit done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (toggle) disp_re = (i % 2 == 0);
         @(negedge pclk);
         if (busy) begin
            n++;
            if (p1_gnt || p2_gnt) gerr++;
         end else begin
            done = 1;
         end
         if (!done) drv();
      end
      chk("sweep_cycles", n, exp_cycles);
      if (toggle) chk("gnt_while_busy", gerr, 0);
      drv();
      disp_re = 1'b0;
      set_req(1, 1'b0, 1'b0, 8'd0, 3'd0);
      set_req(2, 1'b0, 1'b0, 8'd0, 3'd0);
      repeat (2) drv();
      for (int k = 0; k < 400; k++) mdl[k] = 3'd0;
      $display("sweep finished after %0d busy cycles", n);
   endtask

   initial begin
      int n;
      bit got;
      rstn = 1'b1; disp_re = 1'b0; disp_addr = '0; clr_req = 1'b0;
      set_req(1, 1'b1, 1'b0, 8'd0, 3'd0);
      set_req(2, 1'b0, 1'b0, 8'd0, 3'd0);
      for (int k = 0; k < 400; k++) mdl[k] = 3'd0;

      // Reset values
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_p2_rvalid", p2_rvalid, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_p2_rdata", p2_rdata, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      chk("rst_disp_miss", disp_miss, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_busy", busy, 1);
      drv();
      rstn = 1'b0;
      set_req(1, 1'b0, 1'b0, 8'd0, 3'd0);
      count_sweep(0, 400);
      disp_read(0);
      disp_read(399);
      p_access(1, 1'b0, 199, 3'd0);

      // Player separation, out-of-range locals
      p_access(1, 1'b1, 13, 3'd5);
      p_access(2, 1'b0, 13, 3'd0);
      p_access(1, 1'b0, 13, 3'd0);
      p_access(2, 1'b1, 13, 3'd6);
      p_access(2, 1'b0, 13, 3'd0);
      disp_read(213);
      disp_read(13);
      p_access(1, 1'b1, 210, 3'd7);
      p_access(2, 1'b0, 10, 3'd0);
      p_access(1, 1'b1, 12, 3'd2);
      p_access(1, 1'b0, 12, 3'd0);
      p_access(1, 1'b0, 210, 3'd0);
      disp_read(450);

      // Round-robin under contention
      drv();
      set_req(1, 1'b1, 1'b0, 8'd0, 3'd0);
      set_req(2, 1'b1, 1'b0, 8'd0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         chk($sformatf("rr_p1_gnt c%0d", i), p1_gnt, (i % 2 == 0));
         chk($sformatf("rr_p2_gnt c%0d", i), p2_gnt, (i % 2 == 1));
         $display("rr cycle %0d gnt p1=%0d p2=%0d", i, p1_gnt, p2_gnt);
         drv();
      end
      set_req(1, 1'b0, 1'b0, 8'd0, 3'd0);
      set_req(2, 1'b0, 1'b0, 8'd0, 3'd0);
      repeat (2) drv();

      // Display priority over P1
      disp_re = 1'b1; disp_addr = 9'd13;
      set_req(1, 1'b1, 1'b0, 8'd13, 3'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if (p1_gnt) n++;
         drv();
      end
      chk("disp_prio_p1_gnts", n, 0);
      disp_re = 1'b0;
      @(negedge pclk);
      chk("p1_gnt_after_disp", p1_gnt, 1);
      drv();
      set_req(1, 1'b0, 1'b0, 8'd0, 3'd0);
      @(negedge pclk);
      chk("p1_rvalid_after_disp", p1_rvalid, 1);
      chk("p1_rdata_after_disp", p1_rdata, mdl[13]);
      $display("disp priority: p1 granted after display released, data=%0d", p1_rdata);
      repeat (2) drv();

      // Clear sweep with display taking every other cycle
      clr_req = 1'b1;
      drv();
      clr_req = 1'b0;
      set_req(1, 1'b1, 1'b0, 8'd0, 3'd0);
      set_req(2, 1'b1, 1'b0, 8'd0, 3'd0);
      count_sweep(1, 800);
      p_access(1, 1'b0, 13, 3'd0);
      disp_read(213);

      // Reset during a sweep restarts it from address 0
      p_access(2, 1'b1, 150, 3'd4);
      drv();
      clr_req = 1'b1;
      drv();
      clr_req = 1'b0;
      repeat (100) drv();
      rstn = 1'b1;
      drv();
      rstn = 1'b0;
      count_sweep(0, 400);
      p_access(2, 1'b0, 150, 3'd0);

      // Starvation guard (or strict display priority without it)
      p_access(1, 1'b1, 13, 3'd4);
      p_access(2, 1'b1, 20, 3'd3);
      drv();
      disp_re = 1'b1; disp_addr = 9'd13;
      set_req(2, 1'b1, 1'b0, 8'd20, 3'd0);
`ifdef ARB_STARVE_GUARD_EN
      n = 0; got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge pclk);
         n++;
         if (p2_gnt) got = 1;
         else drv();
      end
      chk("starve_gnt_cycle", n, 64);
      drv();
      disp_re = 1'b0;
      set_req(2, 1'b0, 1'b0, 8'd0, 3'd0);
      @(negedge pclk);
      chk("starve_disp_miss", disp_miss, 1);
      chk("starve_disp_rdata", disp_rdata, 0);
      chk("starve_p2_rvalid", p2_rvalid, 1);
      chk("starve_p2_rdata", p2_rdata, 3);
      drv();
      @(negedge pclk);
      chk("starve_disp_miss_pulse", disp_miss, 0);
      $display("starve guard: p2 granted in wait cycle %0d", n);
`else
      n = 0; got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge pclk);
         if (p2_gnt) n++;
         if (disp_miss) got = 1;
         drv();
      end
      chk("strict_prio_p2_gnts", n, 0);
      chk("strict_prio_disp_miss", got, 0);
      chk("strict_prio_disp_rdata", disp_rdata, 4);
      disp_re = 1'b0;
      @(negedge pclk);
      chk("p2_gnt_after_disp", p2_gnt, 1);
      drv();
      set_req(2, 1'b0, 1'b0, 8'd0, 3'd0);
      @(negedge pclk);
      chk("p2_rdata_after_disp", p2_rdata, 3);
      $display("strict priority: p2 granted after display released");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
